countdown_sequencer: RTL

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/egg_timer_pkg.sv | 73 +++++++
 rtl/countdown_sequencer_if.sv | 42 ++++
 rtl/key_edge_detect.sv | 41 ++++
 rtl/countdown_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_pkg
// Purpose  : Shared state encoding, BCD limits and BCD helper functions for
//            the countdown sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package egg_timer_pkg;

  // Width of the visible state code
  localparam int c_state_w = 3;

  // Largest legal BCD settings for seconds and minutes
  localparam logic [7:0] c_sec_max = 8'h59;
  localparam logic [7:0] c_min_max = 8'h99;

  // Sequencer state codes; the two unused codes recover to ST_SET_SEC
  typedef enum logic [c_state_w-1:0] {
    ST_SET_SEC = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_READY   = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Clamp a switch value to a legal seconds setting (00..59)
  function automatic logic [7:0] sanitize_sec(input logic [7:0] sw);
    if ((sw[7:4] > 4'd5) || (sw[3:0] > 4'd9)) begin
      return c_sec_max;
    end
    return sw;
  endfunction

  // Clamp a switch value to a legal minutes setting (00..99)
  function automatic logic [7:0] sanitize_min(input logic [7:0] sw);
    if ((sw[7:4] > 4'd9) || (sw[3:0] > 4'd9)) begin
      return c_min_max;
    end
    return sw;
  endfunction

  // One-second BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}.
  // 00:00 is left unchanged; the sequencer never ticks from that value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] mmss);
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    mt = mmss[15:12];
    mo = mmss[11:8];
    st = mmss[7:4];
    so = mmss[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if ({mt, mo} != 8'h00) begin
      st = 4'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mt = mt - 4'd1;
        mo = 4'd9;
      end
    end
    return {mt, mo, st, so};
  endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_sequencer_if
// Purpose  : Pushbutton/switch inputs and display/status outputs of the
//            countdown sequencer, bundled with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface countdown_sequencer_if;
  import egg_timer_pkg::*;

  logic [1:0]           KEY;    // raw active-low pushbuttons
  logic [7:0]           SW;     // BCD setting value
  logic [c_state_w-1:0] STATE;  // current state code
  logic [7:0]           MIN;    // BCD minutes
  logic [7:0]           SEC;    // BCD seconds
  logic                 DONE;   // high while in DONE
  logic                 TICK;   // one-cycle pulse per countdown tick

  // Environment side: drives buttons and switches, observes the display
  modport master (
    output KEY,
    output SW,
    input  STATE,
    input  MIN,
    input  SEC,
    input  DONE,
    input  TICK
  );

  // Sequencer side
  modport slave (
    input  KEY,
    input  SW,
    output STATE,
    output MIN,
    output SEC,
    output DONE,
    output TICK
  );

endinterface
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : key_edge_detect
// Purpose  : Two-flop synchronizer for one raw active-low pushbutton plus a
//            registered one-cycle press pulse on the synchronized 1->0 edge.
//            The pulse appears three clock edges after the raw fall; holding
//            the button produces exactly one pulse.
// Revision : 1.0 - initial release
// ============================================================================
module key_edge_detect (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_key,
  output logic      o_press
);

  logic r_meta;   // first synchronizer stage
  logic r_sync;   // second synchronizer stage
  logic r_dly;    // previous synchronized level for edge detection
  logic r_press;  // registered press pulse

  // Synchronize the button, remember its last level and flag a falling edge.
  // Flops reset to the released (high) level so reset exit is event-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_dly   <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_key;
      r_sync  <= r_meta;
      r_dly   <= r_sync;
      r_press <= r_dly & ~r_sync;
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_sequencer
// Purpose  : Egg-timer style countdown: set seconds and minutes from BCD
//            switches, then count down once per TICK_DIV clocks with pause,
//            abort and reload-from-preset controls on two pushbuttons.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_sequencer #(
  parameter int TICK_DIV = 50000000   // clocks per countdown tick, >= 2
) (
  input  wire logic             CLK,
  input  wire logic             RESET_N,
  countdown_sequencer_if.slave  bus
);

  import egg_timer_pkg::*;

  localparam int                   c_presc_w    = $clog2(TICK_DIV);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

  // Key press pulses: bit 0 = advance/abort, bit 1 = start/pause
  logic [1:0]           w_press;
  logic                 w_key_adv;
  logic                 w_key_run;

  // Registered state
  state_t               r_state;
  logic [7:0]           r_min;
  logic [7:0]           r_sec;
  logic [15:0]          r_preset;
  logic [c_presc_w-1:0] r_presc;
  logic                 r_tick;
  logic                 r_done;

  // Next-state values
  state_t               w_state_next;
  logic [7:0]           w_min_next;
  logic [7:0]           w_sec_next;
  logic [15:0]          w_preset_next;
  logic [c_presc_w-1:0] w_presc_next;
  logic                 w_tick_next;
  logic                 w_done_next;
  logic [15:0]          w_dec;

  // One synchronizer/edge detector per pushbutton
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_edge_detect u_key (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_key   (bus.KEY[gi]),
        .o_press (w_press[gi])
      );
    end
  endgenerate

  assign w_key_adv = w_press[0];
  assign w_key_run = w_press[1];
  assign w_dec     = bcd_dec({r_min, r_sec});

  // Next-state, count and prescaler logic. Advance/abort is tested first in
  // every state so it wins over a simultaneous start/pause press. In RUN the
  // decrement is applied before the key-driven transition.
  always_comb begin
    w_state_next  = r_state;
    w_min_next    = r_min;
    w_sec_next    = r_sec;
    w_preset_next = r_preset;
    w_presc_next  = r_presc;

    case (r_state)
      ST_SET_SEC: begin
        w_sec_next = sanitize_sec(bus.SW);
        if (w_key_adv) begin
          w_state_next = ST_SET_MIN;
        end
      end

      ST_SET_MIN: begin
        w_min_next = sanitize_min(bus.SW);
        if (w_key_adv) begin
          w_state_next  = ST_READY;
          w_preset_next = {r_min, r_sec};
        end
      end

      ST_READY: begin
        if (w_key_adv) begin
          w_state_next = ST_SET_SEC;
        end else if (w_key_run && ({r_min, r_sec} != 16'h0000)) begin
          w_state_next = ST_RUN;
          w_presc_next = '0;   // only place the prescaler restarts
        end
      end

      ST_RUN: begin
        w_presc_next = (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
        if (r_tick) begin
          {w_min_next, w_sec_next} = w_dec;
        end
        if (w_key_adv) begin
          w_state_next = ST_SET_SEC;
        end else if (r_tick && (w_dec == 16'h0000)) begin
          w_state_next = ST_DONE;
        end else if (w_key_run) begin
          w_state_next = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        // Prescaler and counts hold so RUN resumes mid-second
        if (w_key_adv) begin
          w_state_next = ST_SET_SEC;
        end else if (w_key_run) begin
          w_state_next = ST_RUN;
        end
      end

      ST_DONE: begin
        if (w_key_adv) begin
          w_state_next = ST_SET_SEC;
        end else if (w_key_run) begin
          w_state_next = ST_READY;
          {w_min_next, w_sec_next} = r_preset;
        end
      end

      default: begin
        w_state_next = ST_SET_SEC;
      end
    endcase

    // TICK is registered: it is high during the cycle whose prescaler value
    // is the last count of the second, and only while running.
    w_tick_next = (w_state_next == ST_RUN) && (w_presc_next == c_presc_last);
    w_done_next = (w_state_next == ST_DONE);
  end

  // State, count and status registers with asynchronous clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_SET_SEC;
      r_min    <= 8'h00;
      r_sec    <= 8'h00;
      r_preset <= 16'h0000;
      r_presc  <= '0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_min    <= w_min_next;
      r_sec    <= w_sec_next;
      r_preset <= w_preset_next;
      r_presc  <= w_presc_next;
      r_tick   <= w_tick_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.STATE = r_state;
  assign bus.MIN   = r_min;
  assign bus.SEC   = r_sec;
  assign bus.DONE  = r_done;
  assign bus.TICK  = r_tick;

endmodule
`default_nettype wire
